// File: rtl/aes_job_arbiter_if.sv
// Requester and engine bundle for aes_job_arbiter; the slave modport is the arbiter side.
// Combinational signal bundle, no latency; handshake rules are owned by the arbiter.
// Requesters hold req with stable data until gnt; the engine is never stalled.
interface aes_job_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_last;
    logic [8*NREQ-1:0]     req_csr;
    logic [128*NREQ-1:0]   req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       resp_valid;
    logic [127:0]          resp_data;
    logic                  resp_err;
    logic [7:0]            eng_csr;
    logic [127:0]          eng_data;
    logic                  eng_we;
    logic                  eng_done;
    logic [127:0]          eng_result;
    logic                  busy;

    modport slave (
        input  req, req_last, req_csr, req_data, eng_done, eng_result,
        output gnt, resp_valid, resp_data, resp_err, eng_csr, eng_data, eng_we, busy
    );

    modport master (
        output req, req_last, req_csr, req_data, eng_done, eng_result,
        input  gnt, resp_valid, resp_data, resp_err, eng_csr, eng_data, eng_we, busy
    );
endinterface

// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES engine; chained bursts stay locked to one owner. Optional watchdog: AES_ARB_TIMEOUT_EN.
// Latency: req to gnt/engine start 1 cycle, eng_done to resp_valid 1 cycle, next gnt no earlier than 2 cycles after resp_valid.
// Backpressure: requesters hold req until gnt; non-owners wait through a whole burst; the engine is never stalled.
module aes_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset,
    aes_job_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HOLD} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   pick;
    logic            pick_vld;
    logic            first;
    logic            last;
    logic [7:0]      csr_q;
    logic [127:0]    data_q;
    logic [127:0]    resp_data_q;
    logic            resp_err_q;
    logic            timeout_hit;
    logic [NREQ-1:0] gnt_c;
    logic [NREQ-1:0] resp_valid_c;
    logic [7:0]      eng_csr_c;
    int              idx;

    // Scan from rr_ptr+1 upward; descending loop lets the nearest set bit win.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (bus.req[idx]) begin
                pick     = PW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_c        = '0;
        resp_valid_c = '0;
        eng_csr_c    = csr_q;
        case (state)
            IDLE: begin
                if (pick_vld) state_nxt = ISSUE;
            end
            ISSUE: begin
                gnt_c[owner] = 1'b1;
                eng_csr_c[2] = first;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (bus.eng_done || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                resp_valid_c[owner] = 1'b1;
                state_nxt = (last || resp_err_q) ? IDLE : HOLD;
            end
            HOLD: begin
                if (bus.req[owner]) state_nxt = ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // csr_q always stores bit 2 clear; the start bit is only injected during ISSUE.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner       <= '0;
            rr_ptr      <= PW'(NREQ - 1);
            first       <= 1'b0;
            last        <= 1'b0;
            csr_q       <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner  <= pick;
                        first  <= 1'b1;
                        last   <= bus.req_last[pick];
                        csr_q  <= bus.req_csr[8*int'(pick) +: 8] & 8'hFB;
                        data_q <= bus.req_data[128*int'(pick) +: 128];
                    end
                end
                WAIT: begin
                    if (bus.eng_done) begin
                        resp_data_q <= bus.eng_result;
                        resp_err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data_q <= '0;
                        resp_err_q  <= 1'b1;
                        csr_q       <= '0;
                    end
                end
                RESP: begin
                    if (last || resp_err_q) rr_ptr <= owner;
                end
                HOLD: begin
                    if (bus.req[owner]) begin
                        first  <= 1'b0;
                        last   <= bus.req_last[owner];
                        csr_q  <= bus.req_csr[8*int'(owner) +: 8] & 8'hFB;
                        data_q <= bus.req_data[128*int'(owner) +: 128];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // Fires on the WAIT cycle whose increment would reach TIMEOUT.
    assign timeout_hit  = (state == WAIT) && (({1'b0, wd_cnt} + 9'd1) == 9'(TIMEOUT));
    assign bus.resp_err = resp_err_q;
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = 8'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign bus.resp_err   = 1'b0;
`endif

    assign bus.gnt        = gnt_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_data  = resp_data_q;
    assign bus.eng_csr    = eng_csr_c;
    assign bus.eng_data   = data_q;
    assign bus.eng_we     = (state == ISSUE) && !first;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter: ECB, round-robin, CBC lock, reset, spurious inputs, optional watchdog.
module tb_aes_job_arbiter;
    localparam int NREQ = 4;
    localparam logic [127:0] PT = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic clock;
    logic reset;
    int   total;
    int   passed;
    int   failed;

    aes_job_arbiter_if #(.NREQ(NREQ)) bus ();

    aes_job_arbiter #(.NREQ(NREQ), .TIMEOUT(20)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] csr, input logic [127:0] dat, input logic lst);
        bus.req[i]               = 1'b1;
        bus.req_last[i]          = lst;
        bus.req_csr[8*i +: 8]    = csr;
        bus.req_data[128*i +: 128] = dat;
    endtask

    task automatic clr_req(input int i);
        bus.req[i] = 1'b0;
    endtask

    task automatic engine_done(input logic [127:0] res);
        bus.eng_done   = 1'b1;
        bus.eng_result = res;
        tick();
        bus.eng_done   = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".gnt"},        128'(bus.gnt), 128'h0);
        check({tag, ".resp_valid"}, 128'(bus.resp_valid), 128'h0);
        check({tag, ".resp_data"},  bus.resp_data, 128'h0);
        check({tag, ".resp_err"},   128'(bus.resp_err), 128'h0);
        check({tag, ".eng_csr"},    128'(bus.eng_csr), 128'h0);
        check({tag, ".eng_data"},   bus.eng_data, 128'h0);
        check({tag, ".eng_we"},     128'(bus.eng_we), 128'h0);
        check({tag, ".busy"},       128'(bus.busy), 128'h0);
    endtask

    initial begin
        total          = 0;
        passed         = 0;
        failed         = 0;
        reset          = 1'b1;
        bus.req        = '0;
        bus.req_last   = '0;
        bus.req_csr    = '0;
        bus.req_data   = '0;
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        tick();
        tick();
        reset = 1'b0;
        check_quiet("reset");

        // Single ECB job from requester 2, engine answers 10 cycles after ISSUE.
        set_req(2, 8'h00, PT, 1'b1);
        tick();
        check("ecb.gnt",      128'(bus.gnt), 128'h4);
        check("ecb.start",    128'(bus.eng_csr), 128'h04);
        check("ecb.we0",      128'(bus.eng_we), 128'h0);
        check("ecb.eng_data", bus.eng_data, PT);
        check("ecb.busy",     128'(bus.busy), 128'h1);
        clr_req(2);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("ecb.wait_csr", 128'(bus.eng_csr), 128'h0);
            check("ecb.wait_rv",  128'(bus.resp_valid | bus.gnt), 128'h0);
        end
        engine_done(CT);
        check("ecb.resp_valid", 128'(bus.resp_valid), 128'h4);
        check("ecb.resp_data",  bus.resp_data, CT);
        check("ecb.resp_err",   128'(bus.resp_err), 128'h0);
        tick();
        check("ecb.idle_rv",   128'(bus.resp_valid), 128'h0);
        check("ecb.hold_data", bus.resp_data, CT);
        check("ecb.idle_busy", 128'(bus.busy), 128'h0);

        // Round-robin with all requesters held: order 0,1,2,3,0 after reset.
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h00, 128'(i + 16), 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr.gnt",  128'(bus.gnt), 128'(1 << (k % 4)));
            check("rr.busy", 128'(bus.busy), 128'h1);
            tick();
            check("rr.eng_data", bus.eng_data, 128'((k % 4) + 16));
            engine_done(128'(k + 100));
            check("rr.resp_valid", 128'(bus.resp_valid), 128'(1 << (k % 4)));
            check("rr.resp_data",  bus.resp_data, 128'(k + 100));
            tick();
            check("rr.idle", 128'(bus.busy | (|bus.gnt)), 128'h0);
        end
        bus.req = '0;

        // CBC burst of 3 from requester 1 while requester 3 requests throughout.
        set_req(3, 8'h08, 128'hD3, 1'b1);
        set_req(1, 8'h08, 128'hB1, 1'b0);
        tick();
        check("cbc.gnt1",  128'(bus.gnt), 128'h2);
        check("cbc.start", 128'(bus.eng_csr), 128'h0C);
        check("cbc.we1",   128'(bus.eng_we), 128'h0);
        set_req(1, 8'h08, 128'hB2, 1'b0);
        tick();
        check("cbc.data_held", bus.eng_data, 128'hB1);
        engine_done(128'hC1);
        check("cbc.rv1", 128'(bus.resp_valid), 128'h2);
        tick();
        check("cbc.hold_gnt",  128'(bus.gnt), 128'h0);
        check("cbc.hold_busy", 128'(bus.busy), 128'h1);
        tick();
        check("cbc.gnt2",  128'(bus.gnt), 128'h2);
        check("cbc.we2",   128'(bus.eng_we), 128'h1);
        check("cbc.csr2",  128'(bus.eng_csr), 128'h08);
        check("cbc.data2", bus.eng_data, 128'hB2);
        set_req(1, 8'h08, 128'hB3, 1'b1);
        tick();
        engine_done(128'hC2);
        check("cbc.rv2", 128'(bus.resp_valid), 128'h2);
        tick();
        check("cbc.hold2_gnt", 128'(bus.gnt), 128'h0);
        tick();
        check("cbc.gnt3",  128'(bus.gnt), 128'h2);
        check("cbc.we3",   128'(bus.eng_we), 128'h1);
        check("cbc.data3", bus.eng_data, 128'hB3);
        clr_req(1);
        tick();
        engine_done(128'hC3);
        check("cbc.rv3",   128'(bus.resp_valid), 128'h2);
        check("cbc.rd3",   bus.resp_data, 128'hC3);
        tick();
        check("cbc.gap",   128'(bus.gnt), 128'h0);
        tick();
        check("cbc.gnt_r3", 128'(bus.gnt), 128'h8);
        check("cbc.csr_r3", 128'(bus.eng_csr), 128'h0C);
        clr_req(3);
        tick();
        engine_done(128'hC4);
        check("cbc.rv_r3", 128'(bus.resp_valid), 128'h8);
        tick();

        // Reset while WAIT discards the job; requester 0 wins afterwards.
        set_req(2, 8'h10, 128'hAA, 1'b1);
        tick();
        clr_req(2);
        tick();
        check("rst.busy_before", 128'(bus.busy), 128'h1);
        pulse_reset();
        check_quiet("rst.mid");
        tick();
        check("rst.no_rv", 128'(bus.resp_valid), 128'h0);
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h00, 128'(i), 1'b1);
        tick();
        check("rst.gnt0", 128'(bus.gnt), 128'h1);
        bus.req = '0;
        tick();
        engine_done(128'h55);
        check("rst.rv0", 128'(bus.resp_valid), 128'h1);
        tick();

        // Spurious eng_done in IDLE, then in HOLD with a withdrawn request from 3.
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        check("spur.idle_gnt", 128'(bus.gnt | bus.resp_valid), 128'h0);
        check("spur.idle_busy", 128'(bus.busy), 128'h0);
        set_req(0, 8'h08, 128'hE1, 1'b0);
        tick();
        check("spur.gnt0", 128'(bus.gnt), 128'h1);
        clr_req(0);
        tick();
        engine_done(128'hF1);
        check("spur.rv0", 128'(bus.resp_valid), 128'h1);
        tick();
        set_req(3, 8'h00, 128'hE3, 1'b1);
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        clr_req(3);
        check("spur.hold_out", 128'(bus.gnt | bus.resp_valid), 128'h0);
        check("spur.hold_busy", 128'(bus.busy), 128'h1);
        tick();
        check("spur.hold2", 128'(bus.gnt | bus.resp_valid), 128'h0);
        set_req(0, 8'h08, 128'hE2, 1'b1);
        tick();
        check("spur.gnt0b", 128'(bus.gnt), 128'h1);
        check("spur.we",    128'(bus.eng_we), 128'h1);
        clr_req(0);
        tick();
        engine_done(128'hF2);
        check("spur.rv0b", 128'(bus.resp_valid), 128'h1);
        tick();
        tick();
        check("spur.withdrawn", 128'(bus.gnt | bus.resp_valid), 128'h0);
        check("spur.end_busy",  128'(bus.busy), 128'h0);

`ifdef AES_ARB_TIMEOUT_EN
        // Watchdog: no eng_done gives an error response 21 cycles after ISSUE.
        set_req(1, 8'h08, 128'h77, 1'b0);
        tick();
        check("to.gnt", 128'(bus.gnt), 128'h2);
        clr_req(1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("to.wait_rv", 128'(bus.resp_valid), 128'h0);
        end
        tick();
        check("to.rv",      128'(bus.resp_valid), 128'h2);
        check("to.err",     128'(bus.resp_err), 128'h1);
        check("to.data",    bus.resp_data, 128'h0);
        check("to.csr",     128'(bus.eng_csr), 128'h0);
        tick();
        check("to.released", 128'(bus.busy), 128'h0);
        // eng_done on the timeout cycle wins.
        set_req(2, 8'h00, 128'h88, 1'b1);
        tick();
        clr_req(2);
        for (int k = 1; k <= 20; k++) tick();
        engine_done(128'h99);
        check("to.race_rv",   128'(bus.resp_valid), 128'h4);
        check("to.race_err",  128'(bus.resp_err), 128'h0);
        check("to.race_data", bus.resp_data, 128'h99);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
